axi_reg_bridge: RTL and testbench
=================================

Name: axi_reg_bridge

Overview:
AXI4-Lite slave front end, 64-bit data, instantiated directly inside top behind the S_AXI_* port set.
Converts host AXI write and read transactions into single-cycle register-bus strobes for the replica/annealing core register file.
Returns the core's read data to AXI, with variable core read latency guarded by a watchdog.
Sole consumer of the S_AXI_* channels; sole producer of the reg_* bus.

Parameters:
AXI_ADDR_W, 32, AXI address width
REG_AW, 16, byte-address bits decoded as register space; bits [AXI_ADDR_W-1:REG_AW] nonzero means a decode error
RD_TIMEOUT, 255, max cycles to wait for reg_rd_valid before an SLVERR response (8-bit counter)

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset; asynchronous, active-low
S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  AXI_ADDR_W/1/1  write address channel
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  64/8/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  AXI_ADDR_W/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  64/2/1/1  read data channel
reg_wr_en  out  1  one-cycle write strobe
reg_wr_addr  out  REG_AW-3  64-bit word index, AWADDR[REG_AW-1:3]
reg_wr_data  out  64  write data
reg_wr_strb  out  8  byte enables
reg_rd_en  out  1  one-cycle read strobe
reg_rd_addr  out  REG_AW-3  word index, ARADDR[REG_AW-1:3]
reg_rd_data  in  64  read data, sampled when reg_rd_valid=1
reg_rd_valid  in  1  core read completion, 1 or more cycles after reg_rd_en

Behaviour:
- Reset (ARESETN=0, asynchronous): both FSMs go to IDLE.
  - All outputs 0 except AWREADY=WREADY=ARREADY=1.
  - In-flight transactions are dropped; no B or R response is issued for them.
  - Captured address, data and strb registers are cleared.
- Write FSM states: W_IDLE, W_ISSUE, W_RESP.
  - In W_IDLE, AW and W are captured independently, in either order or in the same cycle.
  - AWREADY drops once AW is held; WREADY drops once W is held.
  - When both are held: next cycle is W_ISSUE.
  - W_ISSUE lasts one cycle. reg_wr_en=1 only if the address decodes (upper bits 0); otherwise no strobe and BRESP=2'b11.
  - W_RESP: BVALID=1, BRESP 2'b00 or 2'b11, held stable until BREADY. Handshake cycle returns to W_IDLE with AWREADY=WREADY=1.
  - Minimum latency: AW+W accepted in cycle 0, reg_wr_en in cycle 1, BVALID in cycle 2.
- Read FSM states: R_IDLE, R_ISSUE, R_WAIT, R_RESP.
  - R_IDLE: ARREADY=1. AR handshake captures the address and goes to R_ISSUE.
  - R_ISSUE: reg_rd_en=1 for one cycle, then R_WAIT.
  - Decode error: skip R_ISSUE/R_WAIT; go to R_RESP with RDATA=0, RRESP=2'b11.
  - R_WAIT: the timeout counter increments each cycle.
    - reg_rd_valid=1: latch reg_rd_data, RRESP=2'b00, go to R_RESP.
    - Counter reaches RD_TIMEOUT: RDATA=0, RRESP=2'b10, go to R_RESP.
    - reg_rd_valid in the same cycle as timeout: data wins, OKAY.
  - reg_rd_valid outside R_WAIT is ignored.
  - R_RESP: RVALID held with stable data until RREADY, then R_IDLE.
- Collision: if W_ISSUE and R_ISSUE would occur in the same cycle, the write issues and the read stays in R_ISSUE one more cycle.
  - reg_wr_en and reg_rd_en are never high together.
  - A read issued after a write to the same word observes the written value.
- One outstanding transaction per channel; no bursts. AWPROT/ARPROT are not used.
- reg_*_addr and reg_wr_data/strb stay stable from the strobe cycle until the next capture.
- VALID outputs never depend combinationally on READY inputs.
- Target size: ~200 lines.

Test Plan:
- Same-cycle AW=0x0000_0010, W=0x1122_3344_5566_7788, WSTRB=0xFF -> reg_wr_en in cycle 1 with addr 2 and that data; BVALID in cycle 2, BRESP=00; AWREADY/WREADY low until the B handshake.
- W presented 3 cycles before AW=0x18 with WSTRB=0x0F -> one reg_wr_en, addr 3, strb 0x0F; BREADY held low 5 cycles -> BVALID and BRESP stable throughout.
- Read ARADDR=0x20, core returns 0xDEAD_BEEF_0000_0001 four cycles after reg_rd_en -> RDATA equals that value, RRESP=00; RREADY delayed 2 cycles -> data held.
- Read with the core never asserting reg_rd_valid -> RVALID exactly RD_TIMEOUT cycles after R_WAIT entry, RRESP=10, RDATA=0; the next read succeeds normally.
- Write to AWADDR=0x0001_0000 and read of ARADDR=0x8000_0000 -> no reg strobes; BRESP=11; RRESP=11 with RDATA=0.
- Write and read to word 5 arriving in the same cycle -> reg_wr_en in cycle 1, reg_rd_en in cycle 2, never both high.
- Assert ARESETN=0 mid-R_WAIT -> outputs clear asynchronously; after release there is no stale RVALID and the ready signals are 1.

Source files
------------

// File: rtl/axi_reg_bridge_if.sv
// AXI4-Lite slave-side channel bundle for axi_reg_bridge.
// AW/W/B/AR/R channels, 64-bit data; slave = bridge, master = host.
interface axi_reg_bridge_if #(
  parameter int AXI_ADDR_W = 32
);
  logic [AXI_ADDR_W-1:0] S_AXI_AWADDR;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [63:0]           S_AXI_WDATA;
  logic [7:0]            S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [AXI_ADDR_W-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [63:0]           S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_reg_bridge.sv
// AXI4-Lite (64-bit) to single-cycle register-bus bridge with read watchdog.
// Ports: S_AXI_ACLK/ARESETN, s_axi (slave modport), reg_wr_*, reg_rd_*.
module axi_reg_bridge #(
  parameter int AXI_ADDR_W = 32,
  parameter int REG_AW     = 16,
  parameter int RD_TIMEOUT = 255
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  axi_reg_bridge_if.slave   s_axi,
  output logic              reg_wr_en,
  output logic [REG_AW-4:0] reg_wr_addr,
  output logic [63:0]       reg_wr_data,
  output logic [7:0]        reg_wr_strb,
  output logic              reg_rd_en,
  output logic [REG_AW-4:0] reg_rd_addr,
  input  logic [63:0]       reg_rd_data,
  input  logic              reg_rd_valid
);
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_ISSUE = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ISSUE = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;
  localparam logic [1:0] R_RESP  = 2'd3;

  localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

  logic [1:0]        w_st_q, w_st_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [REG_AW-4:0] aw_idx_q, aw_idx_d;
  logic              aw_err_q, aw_err_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;

  logic [1:0]        r_st_q, r_st_d;
  logic [REG_AW-4:0] ar_idx_q, ar_idx_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [7:0]        cnt_q, cnt_d;

  logic aw_hs, w_hs, ar_hs, rd_block;
  logic aw_bad, ar_bad;
  logic unused_ok;

  assign unused_ok = ^{s_axi.S_AXI_AWADDR[2:0],
                       s_axi.S_AXI_ARADDR[2:0]};

  assign aw_bad = |s_axi.S_AXI_AWADDR[AXI_ADDR_W-1:REG_AW];
  assign ar_bad = |s_axi.S_AXI_ARADDR[AXI_ADDR_W-1:REG_AW];

  assign s_axi.S_AXI_AWREADY = (w_st_q == W_IDLE) && !aw_held_q;
  assign s_axi.S_AXI_WREADY  = (w_st_q == W_IDLE) && !w_held_q;
  assign s_axi.S_AXI_ARREADY = (r_st_q == R_IDLE);

  assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;

  assign s_axi.S_AXI_BVALID = (w_st_q == W_RESP);
  assign s_axi.S_AXI_BRESP  = s_axi.S_AXI_BVALID ? bresp_q : 2'b00;
  assign s_axi.S_AXI_RVALID = (r_st_q == R_RESP);
  assign s_axi.S_AXI_RRESP  = s_axi.S_AXI_RVALID ? rresp_q : 2'b00;
  assign s_axi.S_AXI_RDATA  = s_axi.S_AXI_RVALID ? rdata_q : 64'd0;

  // A write issue slot always wins; the read strobe slips a cycle.
  assign rd_block = (w_st_q == W_ISSUE);

  assign reg_wr_en   = (w_st_q == W_ISSUE) && !aw_err_q;
  assign reg_wr_addr = aw_idx_q;
  assign reg_wr_data = wdata_q;
  assign reg_wr_strb = wstrb_q;
  assign reg_rd_en   = (r_st_q == R_ISSUE) && !rd_block;
  assign reg_rd_addr = ar_idx_q;

  always_comb begin
    w_st_d    = w_st_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    aw_err_d  = aw_err_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    unique case (w_st_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_idx_d  = s_axi.S_AXI_AWADDR[REG_AW-1:3];
          aw_err_d  = aw_bad;
          aw_held_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = s_axi.S_AXI_WDATA;
          wstrb_d  = s_axi.S_AXI_WSTRB;
          w_held_d = 1'b1;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs))
          w_st_d = W_ISSUE;
      end
      W_ISSUE: begin
        bresp_d   = aw_err_q ? 2'b11 : 2'b00;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        w_st_d    = W_RESP;
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) w_st_d = W_IDLE;
      end
      default: w_st_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_st_d   = r_st_q;
    ar_idx_d = ar_idx_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    cnt_d    = cnt_q;
    unique case (r_st_q)
      R_IDLE: begin
        if (ar_hs) begin
          ar_idx_d = s_axi.S_AXI_ARADDR[REG_AW-1:3];
          cnt_d    = 8'd0;
          if (ar_bad) begin
            rdata_d = 64'd0;
            rresp_d = 2'b11;
            r_st_d  = R_RESP;
          end else begin
            r_st_d = R_ISSUE;
          end
        end
      end
      R_ISSUE: begin
        if (!rd_block) begin
          cnt_d  = 8'd0;
          r_st_d = R_WAIT;
        end
      end
      R_WAIT: begin
        // Data arriving on the final watchdog cycle still wins.
        if (reg_rd_valid) begin
          rdata_d = reg_rd_data;
          rresp_d = 2'b00;
          r_st_d  = R_RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = 64'd0;
          rresp_d = 2'b10;
          r_st_d  = R_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      R_RESP: begin
        if (s_axi.S_AXI_RREADY) r_st_d = R_IDLE;
      end
      default: r_st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_st_q    <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      wdata_q   <= 64'd0;
      wstrb_q   <= 8'd0;
      bresp_q   <= 2'b00;
      r_st_q    <= R_IDLE;
      ar_idx_q  <= '0;
      rdata_q   <= 64'd0;
      rresp_q   <= 2'b00;
      cnt_q     <= 8'd0;
    end else begin
      w_st_q    <= w_st_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_err_q  <= aw_err_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      r_st_q    <= r_st_d;
      ar_idx_q  <= ar_idx_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axi_reg_bridge.sv
// Directed self-checking bench for axi_reg_bridge.
// Scenario tasks run in sequence; strobe monitor runs alongside.
module tb_axi_reg_bridge;
  localparam int RD_TIMEOUT = 255;

  logic        clk;
  logic        rst_n;
  logic        reg_wr_en;
  logic [12:0] reg_wr_addr;
  logic [63:0] reg_wr_data;
  logic [7:0]  reg_wr_strb;
  logic        reg_rd_en;
  logic [12:0] reg_rd_addr;
  logic [63:0] reg_rd_data;
  logic        reg_rd_valid;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;

  axi_reg_bridge_if #(.AXI_ADDR_W(32)) bus ();

  axi_reg_bridge #(
    .AXI_ADDR_W(32),
    .REG_AW(16),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi(bus),
    .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb),
    .reg_rd_en(reg_rd_en),
    .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data),
    .reg_rd_valid(reg_rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr_en) wr_cnt++;
      if (reg_rd_en) rd_cnt++;
      if (reg_wr_en && reg_rd_en) begin
        checks++;
        failures++;
        $display("FAIL strobe_overlap wr_en=%0b rd_en=%0b want not both",
                 reg_wr_en, reg_rd_en);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;
    reg_rd_data       = '0;
    reg_rd_valid      = 1'b0;
  endtask

  // Drives one write; returns BRESP and whether B arrived in budget.
  task automatic write_txn(input logic [31:0] a, input logic [63:0] d,
                           input logic [7:0] s, output logic [1:0] br,
                           output bit ok);
    ok = 0;
    br = 2'b00;
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_WVALID  = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.S_AXI_BVALID) begin
        br = bus.S_AXI_BRESP;
        ok = 1;
        break;
      end
      tick();
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
  endtask

  // Drives one read; core answers lat cycles after reg_rd_en
  // (lat=0: never). Returns data, resp, strobe cycle, RVALID cycle.
  task automatic read_txn(input logic [31:0] a, input int lat,
                          input logic [63:0] d, output logic [63:0] rd,
                          output logic [1:0] rr, output int ce,
                          output int cv);
    ce = -1;
    cv = -1;
    rd = '0;
    rr = 2'b00;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    for (int c = 1; c < 400; c++) begin
      if (bus.S_AXI_RVALID) begin
        rd = bus.S_AXI_RDATA;
        rr = bus.S_AXI_RRESP;
        cv = c;
        break;
      end
      if (reg_rd_en && ce < 0) ce = c;
      reg_rd_data  = d;
      reg_rd_valid = (ce >= 0) && (lat > 0) && (c == ce + lat);
      tick();
    end
    reg_rd_valid     = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    got = {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
           bus.S_AXI_BVALID, bus.S_AXI_RVALID, reg_wr_en, reg_rd_en};
    checks++;
    if (got !== 7'b1110000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=1110000", got);
    end
    checks++;
    if ({reg_wr_addr, reg_wr_data, reg_wr_strb, reg_rd_addr,
         bus.S_AXI_RDATA, bus.S_AXI_BRESP, bus.S_AXI_RRESP} !== '0) begin
      failures++;
      $display("FAIL reset_data wr_addr=%h wr_data=%h strb=%h rd_addr=%h",
               reg_wr_addr, reg_wr_data, reg_wr_strb, reg_rd_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_same_cycle_write();
    bus.S_AXI_AWADDR  = 32'h0000_0010;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = 64'h1122_3344_5566_7788;
    bus.S_AXI_WSTRB   = 8'hFF;
    bus.S_AXI_WVALID  = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    checks++;
    if ({reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_strb} !==
        {1'b1, 13'd2, 64'h1122_3344_5566_7788, 8'hFF}) begin
      failures++;
      $display("FAIL sc_strobe en=%0b addr=%0d data=%h strb=%h want 1 2 1122334455667788 ff",
               reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_strb);
    end
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID} !== 3'b000) begin
      failures++;
      $display("FAIL sc_c1_ready aw=%0b w=%0b bv=%0b want 000",
               bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID);
    end
    tick();
    checks++;
    if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY,
         bus.S_AXI_WREADY, reg_wr_en} !== 6'b100000) begin
      failures++;
      $display("FAIL sc_bresp bv=%0b br=%b aw=%0b w=%0b en=%0b want 1 00 0 0 0",
               bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY,
               bus.S_AXI_WREADY, reg_wr_en);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    checks++;
    if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b011) begin
      failures++;
      $display("FAIL sc_after_b bv=%0b aw=%0b w=%0b want 011",
               bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY);
    end
  endtask

  task automatic test_w_before_aw();
    int w0;
    int bad;
    w0 = wr_cnt;
    bus.S_AXI_WDATA  = 64'hA5A5_0000_FFFF_1234;
    bus.S_AXI_WSTRB  = 8'h0F;
    bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    checks++;
    if ({bus.S_AXI_WREADY, bus.S_AXI_AWREADY, reg_wr_en} !== 3'b010) begin
      failures++;
      $display("FAIL wf_held w=%0b aw=%0b en=%0b want 010",
               bus.S_AXI_WREADY, bus.S_AXI_AWREADY, reg_wr_en);
    end
    tick();
    tick();
    bus.S_AXI_AWADDR  = 32'h0000_0018;
    bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    checks++;
    if ({reg_wr_en, reg_wr_addr, reg_wr_strb, reg_wr_data} !==
        {1'b1, 13'd3, 8'h0F, 64'hA5A5_0000_FFFF_1234}) begin
      failures++;
      $display("FAIL wf_strobe en=%0b addr=%0d strb=%h data=%h want 1 3 0f a5a50000ffff1234",
               reg_wr_en, reg_wr_addr, reg_wr_strb, reg_wr_data);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!bus.S_AXI_BVALID || bus.S_AXI_BRESP !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wf_b_stable bad_cycles=%0d want 0", bad);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    checks++;
    if (bus.S_AXI_BVALID !== 1'b0 || wr_cnt != w0 + 1) begin
      failures++;
      $display("FAIL wf_done bv=%0b strobes=%0d want 0 1",
               bus.S_AXI_BVALID, wr_cnt - w0);
    end
  endtask

  task automatic test_read_latency();
    int bad;
    bus.S_AXI_ARADDR  = 32'h0000_0020;
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    checks++;
    if ({reg_rd_en, reg_rd_addr} !== {1'b1, 13'd4}) begin
      failures++;
      $display("FAIL rl_strobe en=%0b addr=%0d want 1 4", reg_rd_en, reg_rd_addr);
    end
    bad = 0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (bus.S_AXI_RVALID) bad++;
    end
    reg_rd_data  = 64'hDEAD_BEEF_0000_0001;
    reg_rd_valid = 1'b1;
    tick();
    reg_rd_valid = 1'b0;
    reg_rd_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rl_early early_rvalid=%0d want 0", bad);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA} !==
          {1'b1, 2'b00, 64'hDEAD_BEEF_0000_0001}) begin
        failures++;
        $display("FAIL rl_hold%0d rv=%0b rr=%b rd=%h want 1 00 deadbeef00000001",
                 i, bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA);
      end
      if (i < 2) tick();
    end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    checks++;
    if ({bus.S_AXI_RVALID, bus.S_AXI_ARREADY} !== 2'b01) begin
      failures++;
      $display("FAIL rl_done rv=%0b ar=%0b want 0 1",
               bus.S_AXI_RVALID, bus.S_AXI_ARREADY);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] rd;
    logic [1:0]  rr;
    int ce, cv;
    read_txn(32'h0000_0028, 0, 64'h0, rd, rr, ce, cv);
    checks++;
    if (ce != 1 || cv - (ce + 1) != RD_TIMEOUT) begin
      failures++;
      $display("FAIL to_cycles en_cycle=%0d wait=%0d want 1 %0d",
               ce, cv - (ce + 1), RD_TIMEOUT);
    end
    checks++;
    if ({rr, rd} !== {2'b10, 64'd0}) begin
      failures++;
      $display("FAIL to_resp rr=%b rd=%h want 10 0", rr, rd);
    end
    read_txn(32'h0000_0030, 1, 64'h0123_4567_89AB_CDEF, rd, rr, ce, cv);
    checks++;
    if ({rr, rd} !== {2'b00, 64'h0123_4567_89AB_CDEF} || cv != 3) begin
      failures++;
      $display("FAIL to_next rr=%b rd=%h cyc=%0d want 00 0123456789abcdef 3",
               rr, rd, cv);
    end
  endtask

  task automatic test_decode_err();
    logic [63:0] rd;
    logic [1:0]  rr, br;
    int ce, cv, w0, r0;
    bit ok;
    w0 = wr_cnt;
    r0 = rd_cnt;
    write_txn(32'h0001_0000, 64'h5555, 8'hFF, br, ok);
    checks++;
    if (!ok || br !== 2'b11) begin
      failures++;
      $display("FAIL de_bresp ok=%0b br=%b want 1 11", ok, br);
    end
    read_txn(32'h8000_0000, 2, 64'h7777, rd, rr, ce, cv);
    checks++;
    if ({rr, rd} !== {2'b11, 64'd0} || cv != 1) begin
      failures++;
      $display("FAIL de_rresp rr=%b rd=%h cyc=%0d want 11 0 1", rr, rd, cv);
    end
    checks++;
    if (wr_cnt != w0 || rd_cnt != r0) begin
      failures++;
      $display("FAIL de_strobes wr=%0d rd=%0d want 0 0",
               wr_cnt - w0, rd_cnt - r0);
    end
  endtask

  task automatic test_collision();
    bus.S_AXI_AWADDR  = 32'h0000_0028;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = 64'hCAFE_F00D_1357_2468;
    bus.S_AXI_WSTRB   = 8'hFF;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_ARADDR  = 32'h0000_0028;
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    checks++;
    if ({reg_wr_en, reg_rd_en, reg_wr_addr} !== {2'b10, 13'd5}) begin
      failures++;
      $display("FAIL col_c1 wr=%0b rd=%0b addr=%0d want 1 0 5",
               reg_wr_en, reg_rd_en, reg_wr_addr);
    end
    tick();
    checks++;
    if ({reg_wr_en, reg_rd_en, reg_rd_addr} !== {2'b01, 13'd5}) begin
      failures++;
      $display("FAIL col_c2 wr=%0b rd=%0b addr=%0d want 0 1 5",
               reg_wr_en, reg_rd_en, reg_rd_addr);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    reg_rd_data  = 64'hCAFE_F00D_1357_2468;
    reg_rd_valid = 1'b1;
    tick();
    reg_rd_valid = 1'b0;
    checks++;
    if ({bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA} !==
        {1'b1, 2'b00, 64'hCAFE_F00D_1357_2468}) begin
      failures++;
      $display("FAIL col_rdata rv=%0b rr=%b rd=%h want 1 00 cafef00d13572468",
               bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA);
    end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [63:0] rd;
    logic [1:0]  rr;
    int ce, cv, bad;
    bus.S_AXI_ARADDR  = 32'h0000_0038;
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.S_AXI_ARREADY, bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
         bus.S_AXI_RVALID, reg_rd_en, reg_rd_addr} !== {5'b11100, 13'd0}) begin
      failures++;
      $display("FAIL rst_async ar=%0b aw=%0b w=%0b rv=%0b en=%0b addr=%0d want 1 1 1 0 0 0",
               bus.S_AXI_ARREADY, bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
               bus.S_AXI_RVALID, reg_rd_en, reg_rd_addr);
    end
    reg_rd_valid = 1'b1;
    tick();
    reg_rd_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.S_AXI_RVALID || !bus.S_AXI_ARREADY || !bus.S_AXI_AWREADY ||
          !bus.S_AXI_WREADY)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_after bad_cycles=%0d want 0", bad);
    end
    read_txn(32'h0000_0040, 2, 64'h0F0F_0F0F_F0F0_F0F0, rd, rr, ce, cv);
    checks++;
    if ({rr, rd} !== {2'b00, 64'h0F0F_0F0F_F0F0_F0F0} || cv != 4) begin
      failures++;
      $display("FAIL rst_read rr=%b rd=%h cyc=%0d want 00 0f0f0f0ff0f0f0f0 4",
               rr, rd, cv);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_read_latency();
    test_timeout();
    test_decode_err();
    test_collision();
    test_reset_mid_wait();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
